// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct codes, FSM states,
// and the size/alignment helpers used when a request is accepted.
package lsu_pkg;

   localparam logic [2:0] FN_LBU = 3'b001;
   localparam logic [2:0] FN_LHU = 3'b010;
   localparam logic [2:0] FN_LB  = 3'b011;
   localparam logic [2:0] FN_LH  = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   function automatic logic is_byte(input logic [2:0] funct);
      return (funct == FN_LBU) || (funct == FN_LB);
   endfunction

   function automatic logic is_half(input logic [2:0] funct);
      return (funct == FN_LHU) || (funct == FN_LH);
   endfunction

   // Every funct code that is not a byte or half access is a word access.
   function automatic logic misaligned(input logic [2:0] funct, input logic [1:0] addr_lo);
      if (is_byte(funct))
         return 1'b0;
      else if (is_half(funct))
         return addr_lo[0];
      else
         return addr_lo != 2'b00;
   endfunction

   function automatic logic [3:0] byte_enable(input logic [2:0] funct, input logic [1:0] addr_lo);
      if (is_byte(funct))
         return 4'b0001 << addr_lo;
      else if (is_half(funct))
         return addr_lo[1] ? 4'b1100 : 4'b0011;
      else
         return 4'b1111;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] funct, input logic [31:0] wdata);
      if (is_byte(funct))
         return {4{wdata[7:0]}};
      else if (is_half(funct))
         return {2{wdata[15:0]}};
      else
         return wdata;
   endfunction

endpackage

// File: rtl/lsu_extend.sv
// Selects the addressed byte/half lane of a memory word and zero- or
// sign-extends it according to the load funct code.
module lsu_extend
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  funct,
   input  logic [1:0]  addr_lo,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = word[{addr_lo, 3'b000} +: 8];
      lane_h = addr_lo[1] ? word[31:16] : word[15:0];
      case (funct)
         FN_LBU:  data = {24'h000000, lane_b};
         FN_LB:   data = {{24{lane_b[7]}}, lane_b};
         FN_LHU:  data = {16'h0000, lane_h};
         FN_LH:   data = {{16{lane_h[15]}}, lane_h};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/load_store_ctrl.sv
// Single-outstanding load/store controller: accepts one CPU request, drives a
// simple req/ack memory bus with a wait timeout, and returns a one-cycle response.
module load_store_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic        we_q;
   logic [2:0]  funct_q;
   logic [1:0]  addr_lo_q;
   logic [31:0] rdata_q;
   logic [31:0] ext_data;

   assign req_ready = (state == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         we_q       <= 1'b0;
         funct_q    <= '0;
         addr_lo_q  <= '0;
         rdata_q    <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  funct_q   <= req_funct;
                  addr_lo_q <= req_addr[1:0];
                  rdata_q   <= '0;
                  // Misaligned requests never touch the bus.
                  if (misaligned(req_funct, req_addr[1:0])) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state     <= ST_ISSUE;
                     wait_cnt  <= '0;
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_be    <= byte_enable(req_funct, req_addr[1:0]);
                     mem_wdata <= store_data(req_funct, req_wdata);
                  end
               end
            end
            ST_ISSUE: begin
               if (mem_ack || (wait_cnt == WAIT_LAST)) begin
                  // An ack in the timeout cycle still completes without error.
                  state      <= ST_RESP;
                  rdata_q    <= mem_ack ? mem_rdata : '0;
                  resp_valid <= 1'b1;
                  resp_err   <= !mem_ack;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  mem_addr   <= '0;
                  mem_be     <= '0;
                  mem_wdata  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ST_RESP: begin
               state      <= ST_IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
            end
            default: begin
               state      <= ST_IDLE;
               mem_req    <= 1'b0;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
            end
         endcase
      end
   end

   lsu_extend u_extend (
      .word    (rdata_q),
      .funct   (funct_q),
      .addr_lo (addr_lo_q),
      .data    (ext_data)
   );

   assign resp_rdata = (resp_valid && !we_q && !resp_err) ? ext_data : 32'h0;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed bench for load_store_ctrl: a per-transaction model sets the expected
// outputs each cycle, and hand-computed literals pin the key scenarios.
module tb_load_store_ctrl;
   import lsu_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   logic        check_en = 1'b0;
   logic        exp_ready, exp_mem_req, exp_mem_we, exp_resp_valid, exp_resp_err;
   logic [31:0] exp_mem_addr, exp_mem_wdata, exp_resp_rdata;
   logic [3:0]  exp_mem_be;

   logic [3:0]  seen_be;
   logic [31:0] seen_addr, seen_wdata, seen_rdata;
   logic        seen_we, seen_err;
   int          seen_req_cycles, seen_resp_cycle;

   always #5 clk = ~clk;

   load_store_ctrl #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct  (req_funct),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
      end
   endtask

   function automatic int op_size(input logic [2:0] fn);
      case (fn)
         FN_LBU, FN_LB: return 1;
         FN_LHU, FN_LH: return 2;
         default:       return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] rdata);
      logic [31:0] v;
      case (op_size(fn))
         1: begin
            v = (rdata >> (8 * int'(addr[1:0]))) & 32'h000000FF;
            if (fn == FN_LB && v[7]) v = v | 32'hFFFFFF00;
         end
         2: begin
            v = (rdata >> (16 * int'(addr[1]))) & 32'h0000FFFF;
            if (fn == FN_LH && v[15]) v = v | 32'hFFFF0000;
         end
         default: v = rdata;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] fn, input logic [31:0] wdata);
      case (op_size(fn))
         1:       return (wdata & 32'h000000FF) * 32'h01010101;
         2:       return (wdata & 32'h0000FFFF) * 32'h00010001;
         default: return wdata;
      endcase
   endfunction

   // Compare DUT outputs against the model expectation every cycle.
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
         checkOutput("mem_req", 32'(mem_req), 32'(exp_mem_req));
         checkOutput("resp_valid", 32'(resp_valid), 32'(exp_resp_valid));
         if (exp_mem_req) begin
            checkOutput("mem_addr", mem_addr, exp_mem_addr);
            checkOutput("mem_be", 32'(mem_be), 32'(exp_mem_be));
            checkOutput("mem_we", 32'(mem_we), 32'(exp_mem_we));
            if (exp_mem_we) checkOutput("mem_wdata", mem_wdata, exp_mem_wdata);
         end
         if (exp_resp_valid) begin
            checkOutput("resp_err", 32'(resp_err), 32'(exp_resp_err));
            checkOutput("resp_rdata", resp_rdata, exp_resp_rdata);
         end
      end
   end

   task automatic setIdle();
      exp_ready      = 1'b1;
      exp_mem_req    = 1'b0;
      exp_resp_valid = 1'b0;
   endtask

   task automatic sampleCycle(input int cyc);
      @(negedge clk);
      if (mem_req === 1'b1) begin
         if (seen_req_cycles == 0) begin
            seen_be    = mem_be;
            seen_addr  = mem_addr;
            seen_wdata = mem_wdata;
            seen_we    = mem_we;
         end
         seen_req_cycles++;
      end
      if (resp_valid === 1'b1 && seen_resp_cycle < 0) begin
         seen_resp_cycle = cyc;
         seen_rdata      = resp_rdata;
         seen_err        = resp_err;
      end
      @(posedge clk);
      #1;
   endtask

   // ack_wait = ISSUE cycles without ack before the ack; negative means never.
   task automatic applyStimulus(input logic we, input logic [2:0] fn, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int ack_wait);
      int   sz, n;
      logic mis, err;
      sz  = op_size(fn);
      mis = (int'(addr[1:0]) % sz) != 0;
      err = mis || ack_wait < 0 || ack_wait >= TO;
      n   = mis ? 0 : ((ack_wait < 0 || ack_wait >= TO) ? TO : ack_wait + 1);
      seen_req_cycles = 0;
      seen_resp_cycle = -1;
      seen_be = '0; seen_addr = '0; seen_wdata = '0; seen_rdata = '0; seen_we = 1'b0; seen_err = 1'b0;

      req_valid = 1'b1; req_we = we; req_funct = fn; req_addr = addr; req_wdata = wdata;
      setIdle();
      sampleCycle(0);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      for (int i = 0; i < n; i++) begin
         mem_ack        = (i == ack_wait);
         mem_rdata      = (i == ack_wait) ? rdata : $urandom;
         exp_ready      = 1'b0;
         exp_mem_req    = 1'b1;
         exp_mem_we     = we;
         exp_mem_addr   = addr & 32'hFFFFFFFC;
         exp_mem_be     = 4'(((2 ** sz) - 1) << int'(addr[1:0]));
         exp_mem_wdata  = model_wdata(fn, wdata);
         exp_resp_valid = 1'b0;
         sampleCycle(1 + i);
      end
      mem_ack        = 1'b1;
      mem_rdata      = $urandom;
      exp_ready      = 1'b0;
      exp_mem_req    = 1'b0;
      exp_resp_valid = 1'b1;
      exp_resp_err   = err;
      exp_resp_rdata = (we || err) ? 32'h0 : model_load(fn, addr, rdata);
      sampleCycle(n + 1);
      setIdle();
      sampleCycle(n + 2);
      mem_ack = 1'b0;
   endtask

   initial begin
      #2;
      checkOutput("reset_ready", 32'(req_ready), 32'h1);
      checkOutput("reset_mem_req", 32'(mem_req), 32'h0);
      checkOutput("reset_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("reset_resp_err", 32'(resp_err), 32'h0);
      checkOutput("reset_mem_be", 32'(mem_be), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      setIdle();
      check_en = 1'b1;

      applyStimulus(1'b0, FN_LB, 32'h00000103, 32'h0, 32'h80123456, 2);
      checkOutput("lb_be", 32'(seen_be), 32'h8);
      checkOutput("lb_addr", seen_addr, 32'h00000100);
      checkOutput("lb_rdata", seen_rdata, 32'hFFFFFF80);
      checkOutput("lb_err", 32'(seen_err), 32'h0);
      checkOutput("lb_latency", 32'(seen_resp_cycle), 32'd4);

      applyStimulus(1'b1, FN_LH, 32'h00000202, 32'h0000BEEF, 32'h0, 0);
      checkOutput("sh_we", 32'(seen_we), 32'h1);
      checkOutput("sh_be", 32'(seen_be), 32'hC);
      checkOutput("sh_wdata", seen_wdata, 32'hBEEFBEEF);
      checkOutput("sh_rdata", seen_rdata, 32'h0);
      checkOutput("sh_latency", 32'(seen_resp_cycle), 32'd2);

      applyStimulus(1'b0, 3'b000, 32'h00000301, 32'h0, 32'h0, 0);
      checkOutput("lw_mis_req_cycles", 32'(seen_req_cycles), 32'd0);
      checkOutput("lw_mis_latency", 32'(seen_resp_cycle), 32'd1);
      checkOutput("lw_mis_err", 32'(seen_err), 32'h1);

      applyStimulus(1'b0, 3'b000, 32'h00000400, 32'h0, 32'h0, -1);
      checkOutput("to_req_cycles", 32'(seen_req_cycles), 32'd16);
      checkOutput("to_err", 32'(seen_err), 32'h1);
      checkOutput("to_rdata", seen_rdata, 32'h0);
      checkOutput("to_latency", 32'(seen_resp_cycle), 32'd17);

      applyStimulus(1'b0, 3'b000, 32'h00000404, 32'h0, 32'h13579BDF, 15);
      checkOutput("ack16_err", 32'(seen_err), 32'h0);
      checkOutput("ack16_rdata", seen_rdata, 32'h13579BDF);
      checkOutput("ack16_latency", 32'(seen_resp_cycle), 32'd17);

      applyStimulus(1'b0, FN_LHU, 32'h00000002, 32'h0, 32'h9ABC1234, 1);
      checkOutput("lhu_rdata", seen_rdata, 32'h00009ABC);

      applyStimulus(1'b1, FN_LBU, 32'h00000001, 32'h123456A5, 32'h0, 0);
      checkOutput("sb_be", 32'(seen_be), 32'h2);
      checkOutput("sb_wdata", seen_wdata, 32'hA5A5A5A5);

      applyStimulus(1'b0, FN_LH, 32'h00000000, 32'h0, 32'h00008001, 3);
      checkOutput("lh_rdata", seen_rdata, 32'hFFFF8001);

      applyStimulus(1'b0, FN_LBU, 32'h00000002, 32'h0, 32'h00C30000, 0);
      checkOutput("lbu_rdata", seen_rdata, 32'h000000C3);

      applyStimulus(1'b0, 3'b111, 32'h00000010, 32'h0, 32'hDEADBEEF, 1);
      applyStimulus(1'b1, 3'b000, 32'h00000020, 32'hCAFEF00D, 32'h0, 5);
      applyStimulus(1'b1, FN_LH, 32'h00000203, 32'h1234, 32'h0, 0);
      applyStimulus(1'b0, FN_LHU, 32'h00000001, 32'h0, 32'h0, 0);
      applyStimulus(1'b1, FN_LB, 32'h00000003, 32'h0000007E, 32'h0, 2);
      applyStimulus(1'b0, FN_LB, 32'h00000000, 32'h0, 32'h0000007F, 0);

      // Reset while waiting for ack must abandon the access silently.
      req_valid = 1'b1; req_we = 1'b0; req_funct = 3'b000; req_addr = 32'h00000500;
      setIdle();
      sampleCycle(0);
      req_valid = 1'b0;
      exp_ready = 1'b0; exp_mem_req = 1'b1; exp_mem_we = 1'b0;
      exp_mem_addr = 32'h00000500; exp_mem_be = 4'hF; exp_resp_valid = 1'b0;
      sampleCycle(1);
      sampleCycle(2);
      check_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
      checkOutput("rst_ready", 32'(req_ready), 32'h1);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("rst_hold_resp", 32'(resp_valid), 32'h0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      setIdle();
      check_en = 1'b1;
      repeat (3) sampleCycle(0);

      applyStimulus(1'b1, 3'b000, 32'h00000600, 32'h89ABCDEF, 32'h0, 1);
      checkOutput("post_rst_wdata", seen_wdata, 32'h89ABCDEF);

      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
